// File: rtl/st_fdc_dma.sv
// Floppy-controller DMA bridge: a 16-byte FIFO between a byte-wide device port
// and a 16-bit MCU bus, with 8-word bursts and sector-count bookkeeping.
module st_fdc_dma (
  input  logic        clk32,
  input  logic        resb,
  input  logic        clk_en,
  input  logic        FCS_N,
  input  logic        RW,
  input  logic        A1,
  output logic        RDY_O,
  input  logic        RDY_I,
  input  logic [15:0] DIN,
  output logic [15:0] DOUT,
  input  logic        dev_drq,
  input  logic [7:0]  dev_din,
  output logic [7:0]  dev_dout,
  output logic        dev_ack,
  output logic        error_n
);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t      state_q, state_d;
  logic [15:0] mode_q, mode_d;
  logic [7:0]  sc_q, sc_d;
  logic        error_n_q, error_n_d;
  logic [3:0]  wr_ptr_q, wr_ptr_d;
  logic [3:0]  rd_ptr_q, rd_ptr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [2:0]  wc_q, wc_d;
  logic [8:0]  bc_q, bc_d;
  logic        dev_ack_q, dev_ack_d;
  logic [7:0]  dev_dout_q, dev_dout_d;
  logic [7:0]  fifo_q [16];

  logic        wr_tick, mode_wr, sc_wr, dir_chg, dir_w, sc_nz;
  logic        mcu_xfer, mcu_pop, mcu_push, dev_push, dev_pop, dev_move;
  logic [3:0]  rd_ptr1, wr_ptr1;
  logic [15:0] head_word;
  logic        unused_mode;

  assign unused_mode = ^{mode_q[15:9], mode_q[7:5], mode_q[3:0]};

  assign wr_tick  = clk_en & ~FCS_N & ~RW;
  assign mode_wr  = wr_tick & A1;
  assign sc_wr    = wr_tick & ~A1 & mode_q[4];
  assign dir_chg  = mode_wr & (DIN[8] != mode_q[8]);
  assign dir_w    = mode_q[8];
  assign sc_nz    = (sc_q != 8'd0);

  // A direction change wins over any data movement on the same tick.
  assign mcu_xfer = clk_en & (state_q == S_BURST) & ~RDY_I & ~dir_chg;
  assign mcu_pop  = mcu_xfer & ~dir_w;
  assign mcu_push = mcu_xfer & dir_w;
  assign dev_push = clk_en & dev_drq & ~dir_w & (cnt_q < 5'd16) & sc_nz
                    & ~dev_ack_q & ~dir_chg;
  assign dev_pop  = clk_en & dev_drq & dir_w & (cnt_q != 5'd0)
                    & ~dev_ack_q & ~dir_chg;
  assign dev_move = dev_push | dev_pop;

  assign rd_ptr1   = rd_ptr_q + 4'd1;
  assign wr_ptr1   = wr_ptr_q + 4'd1;
  assign head_word = {fifo_q[rd_ptr_q], fifo_q[rd_ptr1]};

  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    sc_d       = sc_q;
    error_n_d  = error_n_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    wc_d       = wc_q;
    bc_d       = bc_q;
    dev_ack_d  = dev_ack_q;
    dev_dout_d = dev_dout_q;

    if (clk_en) begin
      dev_ack_d = dev_move;
      if (dev_pop) dev_dout_d = fifo_q[rd_ptr_q];
      if (dev_move) bc_d = bc_q + 9'd1;

      rd_ptr_d = rd_ptr_q + {2'b00, mcu_pop, 1'b0} + {3'b000, dev_pop};
      wr_ptr_d = wr_ptr_q + {2'b00, mcu_push, 1'b0} + {3'b000, dev_push};
      cnt_d    = cnt_q + {3'b000, mcu_push, 1'b0} + {4'b0000, dev_push}
                       - {3'b000, mcu_pop, 1'b0} - {4'b0000, dev_pop};

      // Byte counter wrap marks the end of one 512-byte sector.
      if (sc_wr)
        sc_d = DIN[7:0];
      else if (dev_move && (bc_q == 9'd511) && sc_nz)
        sc_d = sc_q - 8'd1;

      if (dev_drq && !sc_nz) error_n_d = 1'b0;

      case (state_q)
        S_IDLE: begin
          if ((!dir_w && (cnt_q == 5'd16)) || (dir_w && (cnt_q == 5'd0) && sc_nz))
            state_d = S_BURST;
        end
        S_BURST: begin
          if (mcu_xfer) begin
            wc_d = wc_q + 3'd1;
            if (wc_q == 3'd7) state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (mode_wr) mode_d = DIN;

      if (dir_chg) begin
        state_d   = S_IDLE;
        wc_d      = 3'd0;
        wr_ptr_d  = 4'd0;
        rd_ptr_d  = 4'd0;
        cnt_d     = 5'd0;
        bc_d      = 9'd0;
        error_n_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      state_q    <= S_IDLE;
      mode_q     <= '0;
      sc_q       <= '0;
      error_n_q  <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      wc_q       <= '0;
      bc_q       <= '0;
      dev_ack_q  <= 1'b0;
      dev_dout_q <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      sc_q       <= sc_d;
      error_n_q  <= error_n_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      wc_q       <= wc_d;
      bc_q       <= bc_d;
      dev_ack_q  <= dev_ack_d;
      dev_dout_q <= dev_dout_d;
    end
  end

  // Storage is cleared on reset so DOUT reads zero until data arrives.
  always_ff @(posedge clk32 or negedge resb) begin
    if (!resb) begin
      for (int i = 0; i < 16; i++) fifo_q[i] <= '0;
    end else begin
      if (dev_push) fifo_q[wr_ptr_q] <= dev_din;
      if (mcu_push) begin
        fifo_q[wr_ptr_q] <= DIN[15:8];
        fifo_q[wr_ptr1]  <= DIN[7:0];
      end
    end
  end

  always_comb begin
    DOUT = 16'h0000;
    if (!FCS_N && RW)
      DOUT = A1 ? {13'b0, dev_drq, sc_nz, error_n_q} : {8'b0, sc_q};
    else if (!RDY_I && FCS_N)
      DOUT = head_word;
  end

  assign RDY_O    = (state_q != S_BURST);
  assign dev_ack  = dev_ack_q;
  assign dev_dout = dev_dout_q;
  assign error_n  = error_n_q;

endmodule

// File: tb/tb_st_fdc_dma.sv
// Scoreboard bench for st_fdc_dma: stimulus queues expected MCU words and
// device bytes, a monitor pops and compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_st_fdc_dma;

  logic        clk32 = 1'b0;
  logic        resb;
  logic        clk_en;
  logic        FCS_N, RW, A1;
  logic        RDY_O, RDY_I;
  logic [15:0] DIN, DOUT;
  logic        dev_drq;
  logic [7:0]  dev_din, dev_dout;
  logic        dev_ack, error_n;

  logic [1:0]  en_cnt = 2'd0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_words [$];
  logic [7:0]  exp_bytes [$];
  logic [7:0]  model_bytes [$];
  bit          chk_bytes = 1'b0;
  logic        prev_ack = 1'b0;

  st_fdc_dma dut (
    .clk32(clk32), .resb(resb), .clk_en(clk_en),
    .FCS_N(FCS_N), .RW(RW), .A1(A1),
    .RDY_O(RDY_O), .RDY_I(RDY_I),
    .DIN(DIN), .DOUT(DOUT),
    .dev_drq(dev_drq), .dev_din(dev_din), .dev_dout(dev_dout),
    .dev_ack(dev_ack), .error_n(error_n)
  );

  always #5 clk32 = ~clk32;
  always @(posedge clk32) en_cnt <= en_cnt + 2'd1;
  assign clk_en = (en_cnt == 2'd3);

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end else
      $display("ok   %s: %h", name, act);
  endtask

  task automatic tick();
    @(posedge clk32);
    while (!clk_en) @(posedge clk32);
    #1;
  endtask

  task automatic reg_write(input logic a1, input logic [15:0] data);
    FCS_N = 1'b0; RW = 1'b0; A1 = a1; DIN = data;
    tick();
    FCS_N = 1'b1; RW = 1'b1; A1 = 1'b0; DIN = 16'h0000;
  endtask

  task automatic reg_read(input logic a1, output logic [15:0] data);
    FCS_N = 1'b0; RW = 1'b1; A1 = a1;
    #1 data = DOUT;
    FCS_N = 1'b1; A1 = 1'b0;
    #1;
  endtask

  task automatic wait_rdy(input logic lvl, input int budget, input string name);
    int t = 0;
    while (RDY_O !== lvl && t < budget) begin
      tick();
      t++;
    end
    check(name, {15'b0, RDY_O}, {15'b0, lvl});
  endtask

  task automatic feed(input int n, input int start);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = 8'(start + i);
      model_bytes.push_back(b);
      dev_drq = 1'b1; dev_din = b;
      tick();
      dev_drq = 1'b0;
      tick();
    end
  endtask

  task automatic drain_words(input int n);
    wait_rdy(1'b0, 40, "burst_req");
    for (int k = 0; k < n; k++) begin
      logic [7:0] hi, lo;
      hi = model_bytes.pop_front();
      lo = model_bytes.pop_front();
      exp_words.push_back({hi, lo});
      RDY_I = 1'b0;
      tick();
    end
    RDY_I = 1'b1;
  endtask

  task automatic do_reset();
    resb = 1'b0;
    #20;
    check("rst_rdy", {15'b0, RDY_O}, 16'h0001);
    check("rst_ack", {15'b0, dev_ack}, 16'h0000);
    check("rst_dout", DOUT, 16'h0000);
    model_bytes.delete();
    @(negedge clk32);
    resb = 1'b1;
    tick();
  endtask

  // Monitor: one sample per tick, on the falling edge just before it.
  initial begin
    forever begin
      @(negedge clk32);
      if (clk_en && resb) begin
        if (!RDY_O && !RDY_I && FCS_N && !chk_bytes) begin
          if (exp_words.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL mcu_word: got %h expected none at %0t", DOUT, $time);
          end else
            check("mcu_word", DOUT, exp_words.pop_front());
        end
        if (dev_ack) begin
          check("ack_gap", {15'b0, prev_ack}, 16'h0000);
          if (chk_bytes) begin
            if (exp_bytes.size() == 0) begin
              n_checks++; n_fail++;
              $display("FAIL dev_byte: got %h expected none at %0t", dev_dout, $time);
            end else
              check("dev_byte", {8'h00, dev_dout}, {8'h00, exp_bytes.pop_front()});
          end
        end
        prev_ack = dev_ack;
      end
    end
  end

  initial begin
    logic [15:0] rd;
    logic [15:0] wr_words [8];
    int t;
    wr_words = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718,
                 16'h293A, 16'h4B5C, 16'h6D7E, 16'h8F90};
    resb = 1'b0; FCS_N = 1'b1; RW = 1'b1; A1 = 1'b0; RDY_I = 1'b1;
    DIN = 16'h0000; dev_drq = 1'b0; dev_din = 8'h00;

    // Reset state
    do_reset();
    check("rst_err", {15'b0, error_n}, 16'h0001);
    check("rst_ddout", {8'h00, dev_dout}, 16'h0000);
    reg_read(1'b0, rd); check("rst_sc", rd, 16'h0000);
    reg_read(1'b1, rd); check("rst_status", rd, 16'h0001);

    // Read direction: 16 bytes then one burst of 8 words
    reg_write(1'b1, 16'h0010);
    reg_write(1'b0, 16'h0001);
    feed(16, 0);
    check("rdy_after_fill", {15'b0, RDY_O}, 16'h0000);
    drain_words(8);
    check("rdy_after_burst", {15'b0, RDY_O}, 16'h0001);
    check("words_left", 16'(exp_words.size()), 16'h0000);
    reg_read(1'b0, rd); check("sc_kept", rd, 16'h0001);

    // Write direction: 8 words in, 16 bytes out to the device
    do_reset();
    chk_bytes = 1'b1;
    reg_write(1'b1, 16'h0110);
    reg_write(1'b0, 16'h0001);
    wait_rdy(1'b0, 10, "wr_burst_req");
    for (int k = 0; k < 8; k++) begin
      exp_bytes.push_back(wr_words[k][15:8]);
      exp_bytes.push_back(wr_words[k][7:0]);
      DIN = wr_words[k]; RDY_I = 1'b0;
      tick();
    end
    RDY_I = 1'b1; DIN = 16'h0000;
    check("wr_burst_end", {15'b0, RDY_O}, 16'h0001);
    dev_drq = 1'b1;
    t = 0;
    while (exp_bytes.size() != 0 && t < 100) begin
      tick();
      t++;
    end
    dev_drq = 1'b0;
    check("bytes_left", 16'(exp_bytes.size()), 16'h0000);
    tick();
    chk_bytes = 1'b0;

    // 512 bytes, sector count runs out, then an extra request errors
    do_reset();
    reg_write(1'b1, 16'h0010);
    reg_write(1'b0, 16'h0001);
    for (int g = 0; g < 32; g++) begin
      feed(16, g * 16);
      drain_words(8);
    end
    check("sector_idle", {15'b0, RDY_O}, 16'h0001);
    reg_read(1'b0, rd); check("sc_zero", rd, 16'h0000);
    reg_read(1'b1, rd); check("status_sc0", rd, 16'h0001);
    dev_drq = 1'b1;
    tick();
    check("err_set", {15'b0, error_n}, 16'h0000);
    reg_read(1'b1, rd); check("status_err", rd, 16'h0004);
    dev_drq = 1'b0;
    #1;
    reg_read(1'b1, rd); check("status_err_nodrq", rd, 16'h0000);

    // Sector write mid-burst, then direction toggle aborts
    do_reset();
    reg_write(1'b1, 16'h0010);
    reg_write(1'b0, 16'h0001);
    feed(16, 8'h40);
    drain_words(3);
    check("rdy_mid", {15'b0, RDY_O}, 16'h0000);
    reg_write(1'b0, 16'h0000);
    check("burst_kept", {15'b0, RDY_O}, 16'h0000);
    reg_read(1'b0, rd); check("sc_mid", rd, 16'h0000);
    dev_drq = 1'b1;
    tick();
    reg_read(1'b1, rd); check("status_mid_err", rd, 16'h0004);
    dev_drq = 1'b0;
    reg_write(1'b0, 16'h0001);
    reg_write(1'b1, 16'h0110);
    check("abort_rdy", {15'b0, RDY_O}, 16'h0001);
    reg_read(1'b1, rd); check("abort_status", rd, 16'h0003);
    tick();
    check("flushed_reburst", {15'b0, RDY_O}, 16'h0000);
    check("abort_words_left", 16'(exp_words.size()), 16'h0000);

    // Asynchronous reset during a burst
    do_reset();
    reg_write(1'b1, 16'h0110);
    reg_write(1'b0, 16'h0005);
    wait_rdy(1'b0, 10, "pre_rst_burst");
    @(negedge clk32);
    #2 resb = 1'b0;
    #1;
    check("async_rdy", {15'b0, RDY_O}, 16'h0001);
    reg_read(1'b0, rd); check("async_sc", rd, 16'h0000);
    reg_read(1'b1, rd); check("async_status", rd, 16'h0001);
    @(negedge clk32);
    resb = 1'b1;
    reg_write(1'b0, 16'h0003);
    reg_read(1'b0, rd); check("sc_wr_ignored", rd, 16'h0000);
    repeat (6) tick();
    check("no_req_after_rst", {15'b0, RDY_O}, 16'h0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/st_fdc_dma.md
ST_FDC_DMA -- requirements
Module: st_fdc_dma

Interface
REQ-001 SHALL have ports: clk32 in 1, system clock; resb in 1, reset, asynchronous, active-low.
REQ-002 SHALL have clk_en in 1, 8 MHz enable; all state changes except reset occur only on clk32 edges with clk_en=1 ("tick").
REQ-003 SHALL have FCS_N in 1, register select from MCU, active-low; RW in 1, 1=read; A1 in 1, register address.
REQ-004 SHALL have RDY_O out 1, active-low burst request to MCU; RDY_I in 1, active-low per-word grant from MCU.
REQ-005 SHALL have DIN in 16, CPU/RAM data; DOUT out 16, register or FIFO data.
REQ-006 SHALL have dev_drq in 1, device byte request; dev_din in 8; dev_dout out 8; dev_ack out 1, byte strobe.
REQ-007 SHALL have error_n out 1, 1=no error.

Function
REQ-008 Registers (tick with FCS_N=0, RW=0): A1=1 writes mode[15:0]; A1=0 writes sector count[7:0] if mode[4]=1, else ignored.
REQ-009 Reads (FCS_N=0, RW=1, combinational): A1=1 -> {13'b0, dev_drq, sc!=0, error_n}; A1=0 -> {8'b0, sector count}.
REQ-010 mode[8] is direction: 0=device->RAM (read), 1=RAM->device (write).
REQ-011 Any mode write whose mode[8] differs from the stored value SHALL flush FIFO, clear byte counter, set error_n=1, abort a running burst.
REQ-012 FIFO: 16 bytes as 8 words; byte count 0..16; big-endian packing, first byte = word[15:8].
REQ-013 States: IDLE, BURST. IDLE->BURST at tick when (mode[8]=0 and FIFO=16 bytes) or (mode[8]=1 and FIFO=0 bytes and sc!=0).
REQ-014 RDY_O SHALL be 0 exactly while in BURST, registered (asserted the tick after the entry condition is met).
REQ-015 In BURST each tick with RDY_I=0 transfers one word: read direction pops head word onto DOUT; write direction pushes DIN.
REQ-016 DOUT SHALL present the FIFO head word whenever RDY_I=0 and FCS_N=1.
REQ-017 After the 8th word, BURST->IDLE and RDY_O=1 on the same tick.
REQ-018 Word counter is 3 bits and wraps 7->0 at burst end.
REQ-019 Device read side: tick with dev_drq=1, mode[8]=0, FIFO<16, sc!=0, dev_ack=0 latches dev_din into FIFO and sets dev_ack=1 for one tick.
REQ-020 Device write side: tick with dev_drq=1, mode[8]=1, FIFO>0, dev_ack=0 pops one byte to dev_dout (held until next pop) and pulses dev_ack for one tick.
REQ-021 No device byte SHALL be moved on the tick following a dev_ack pulse.
REQ-022 A 9-bit byte counter counts device bytes; on wrap 511->0 sector count SHALL decrement by 1, saturating at 0.
REQ-023 dev_drq=1 with sc=0 at a tick SHALL clear error_n to 0; error_n remains 0 until REQ-011 or reset.
REQ-024 FIFO push and pop on the same tick (device and MCU side) SHALL both occur; count changes by net amount.
REQ-025 Sector count write during BURST SHALL be accepted without aborting the burst.

Reset
REQ-026 resb=0 SHALL immediately force: IDLE, RDY_O=1, dev_ack=0, dev_dout=0, DOUT=0 when not reading, mode=0, sc=0, error_n=1, FIFO empty, all counters 0.
REQ-027 Reset mid-burst SHALL drop RDY_O to 1 asynchronously; no word is transferred afterwards.

Verification
REQ-028 Write mode=0x0010, sc=1; feed 16 bytes 0x00..0x0F via dev_drq -> RDY_O=0 next tick; 8 RDY_I pulses yield DOUT 0x0001,0x0203,..,0x0E0F; RDY_O=1 after 8th.
REQ-029 Mode=0x0110, sc=1; RDY_O=0; 8 words 0xA1B2.. on DIN -> dev_dout A1,B2,.. with one dev_ack per byte, never on consecutive ticks.
REQ-030 sc=1, transfer 512 bytes read direction -> sc reads 0, status bit1=0; extra dev_drq -> error_n=0, status=0x0004|0.
REQ-031 Mid-burst (after 3 words) write mode toggling bit 8 -> RDY_O=1 next tick, FIFO empty, error_n=1.
REQ-032 Assert resb=0 during BURST -> RDY_O=1 without clock, sc=0, mode=0; after release no request until conditions re-met.
